// File: rtl/capture_pkg.sv
// Shared types, defaults and sample helpers for the capture write-side controller.
package capture_pkg;

  localparam int unsigned DATA_W_DEF = 14;
  localparam int unsigned CNT_W_DEF  = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Magnitude of a w-bit two's complement value held in the low bits of x.
  // The most-negative code saturates to the largest positive code so the
  // result always fits in w-1 magnitude bits. Valid for w in 2..31.
  function automatic logic [31:0] absSat(input logic [31:0] x, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] signBit;
    logic [31:0] v;
    mask    = (32'd1 << w) - 32'd1;
    signBit = 32'd1 << (w - 1);
    v       = x & mask;
    if (v == signBit) begin
      return signBit - 32'd1;
    end
    if ((v & signBit) != 32'd0) begin
      return ((~v) + 32'd1) & mask;
    end
    return v;
  endfunction

endpackage

// File: rtl/capture_trigger_trig_detect.sv
// Threshold-crossing detector: magnitude compare plus consecutive-sample run counter.
module trig_detect
  import capture_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned TRIG_RUN = 2
) (
  input  logic              wrclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_a,
  input  logic              dec_rdy_a,
  input  logic [DATA_W-1:0] threshold,
  input  logic              enable,
  input  logic              clear,
  output logic              hit
);

  localparam int unsigned RUN_W = 4;

  logic [DATA_W-1:0] mag;
  logic              qual;
  logic [RUN_W-1:0]  runCnt;

  // Saturated magnitude of the current sample, compared unsigned against threshold.
  always_comb begin
    mag  = DATA_W'(absSat(32'(din_a), DATA_W));
    qual = (mag >= threshold);
  end

  // Run counter counts consecutive qualifying strobes; hit pulses for one cycle on reaching TRIG_RUN.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      runCnt <= '0;
      hit    <= 1'b0;
    end else if (clear) begin
      runCnt <= '0;
      hit    <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (enable && dec_rdy_a) begin
        if (qual) begin
          if (runCnt == RUN_W'(TRIG_RUN - 1)) begin
            hit    <= 1'b1;
            runCnt <= '0;
          end else begin
            runCnt <= runCnt + 4'd1;
          end
        end else begin
          runCnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/capture_trigger.sv
// Write-side capture controller: arms, clears the buffer address, triggers and
// enables exactly one bounded block of sample writes per arm request.
module capture_trigger
  import capture_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TRIG_RUN   = 2,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic              wrclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_a,
  input  logic              dec_rdy_a,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] threshold,
  input  logic [CNT_W-1:0]  cap_len,
  input  logic              full,
  output logic              load,
  output logic              store_clr,
  output logic [2:0]        state,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  logic             hit;
  logic             detEn;
  logic             detClr;
  logic [CLR_W-1:0] clrCnt;
  logic             wrStrobe;

  // Detector only runs while armed; any other state or an abort flushes its run counter.
  always_comb begin
    detEn    = (state == ST_ARMED);
    detClr   = (state != ST_ARMED) || abort;
    wrStrobe = dec_rdy_a && load;
  end

  trig_detect #(
    .DATA_W   (DATA_W),
    .TRIG_RUN (TRIG_RUN)
  ) uTrigDetect (
    .wrclk     (wrclk),
    .rst_n     (rst_n),
    .din_a     (din_a),
    .dec_rdy_a (dec_rdy_a),
    .threshold (threshold),
    .enable    (detEn),
    .clear     (detClr),
    .hit       (hit)
  );

  // Capture FSM with registered load/clear/done and the written-sample counter.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      load       <= 1'b0;
      store_clr  <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
      clrCnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state      <= ST_CLEAR;
            store_clr  <= 1'b1;
            clrCnt     <= '0;
            sample_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            state     <= ST_IDLE;
            store_clr <= 1'b0;
            load      <= 1'b0;
          end else if (clrCnt == CLR_W'(CLR_CYCLES - 1)) begin
            state     <= ST_ARMED;
            store_clr <= 1'b0;
          end else begin
            clrCnt <= clrCnt + CLR_W'(1);
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state <= ST_IDLE;
            load  <= 1'b0;
          end else if (hit || force_trig) begin
            state <= ST_CAPTURE;
            load  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            state <= ST_IDLE;
            load  <= 1'b0;
          end else if (wrStrobe && (sample_cnt == cap_len)) begin
            // Last sample is written on this edge; count stops at cap_len so it never wraps.
            state <= ST_DONE;
            load  <= 1'b0;
            done  <= 1'b1;
          end else begin
            if (wrStrobe) begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (full) begin
              state <= ST_DONE;
              load  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (arm) begin
            state      <= ST_CLEAR;
            done       <= 1'b0;
            store_clr  <= 1'b1;
            clrCnt     <= '0;
            sample_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          load      <= 1'b0;
          store_clr <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_trigger.md
Name: capture_trigger

Overview:
- Upstream write-side controller for the synchronous capture buffer.
- Watches channel A ADC samples on the write clock and detects a threshold crossing (or a software force).
- Drives the buffer's `load` enable and clear pulse, so exactly one bounded block of samples is written per arm request.
- Reports status (state, done, sample count) to the host-interface register logic.

Parameters:
- DATA_W, 14, ADC sample width; samples are two's complement.
- CNT_W, 13, width of the capture-length counter; matches the buffer address width.
- TRIG_RUN, 2, number of consecutive qualifying strobed samples needed to fire the trigger (1..15).
- CLR_CYCLES, 2, number of cycles `store_clr` is held high before the block goes to ARMED.

Ports:
- wrclk, in, 1, ADC/data clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- din_a, in, DATA_W, channel A sample; valid only when dec_rdy_a=1.
- dec_rdy_a, in, 1, sample strobe from the decimator.
- arm, in, 1, single-cycle request to start a new capture.
- abort, in, 1, single-cycle request to cancel the capture and return to IDLE.
- force_trig, in, 1, software trigger; acts only in ARMED.
- threshold, in, DATA_W, unsigned magnitude threshold.
- cap_len, in, CNT_W, number of samples to capture minus 1.
- full, in, 1, buffer full flag from the storage stage.
- load, out, 1, registered write enable to storage; storage writes when load && dec_rdy_a.
- store_clr, out, 1, registered active-high clear for the storage write address.
- state, out, 3, current FSM state encoding.
- done, out, 1, high while in DONE.
- sample_cnt, out, CNT_W, number of samples written in the current capture.

Behaviour:
- Reset values: load=0, store_clr=0, done=0, sample_cnt=0, state=IDLE, run counter=0.
- States: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, DONE=4. Encodings 5..7 are illegal and recover to IDLE on the next cycle.
- IDLE, or DONE, with arm=1: go to CLEAR.
  - store_clr=1 for CLR_CYCLES cycles, starting the cycle after arm.
  - sample_cnt is cleared.
  - Then go to ARMED with store_clr=0.
- ARMED, magnitude rule:
  - mag = |din_a|, computed on DATA_W bits.
  - The most-negative code saturates to 2^(DATA_W-1)-1 (8191 at the default width).
- ARMED, qualifying sample: dec_rdy_a && mag >= threshold.
  - A qualifying sample increments the run counter.
  - A strobed non-qualifying sample clears the run counter.
  - Cycles with dec_rdy_a=0 leave the run counter unchanged.
- ARMED, trigger:
  - The trigger fires when the run counter reaches TRIG_RUN, or when force_trig=1.
  - Next state is CAPTURE, with load=1 from the following cycle.
  - The triggering sample itself is not stored.
- CAPTURE:
  - sample_cnt increments on each cycle with dec_rdy_a && load.
  - Exit to DONE when dec_rdy_a && sample_cnt==cap_len (cap_len+1 samples written), or when full=1.
  - load drops in the same edge as the transition, so no extra write occurs.
- DONE: holds, with load=0 and done=1, until arm or abort.
- abort in any state except IDLE:
  - Next state is IDLE; load=0, store_clr=0, run counter cleared.
  - sample_cnt holds its value for readback.
- Simultaneous events:
  - abort has priority over arm, trigger and end-of-capture.
  - In ARMED, force_trig and a threshold trigger in the same cycle act as a single trigger.
  - arm in CLEAR, ARMED or CAPTURE is ignored.
- Boundaries:
  - cap_len=0 captures exactly one sample.
  - cap_len=2^CNT_W-1 captures until full or the count matches; sample_cnt never wraps.
  - threshold=0 triggers on every strobed sample.
  - threshold is compared unsigned against mag.
- threshold and cap_len are sampled continuously; software changes them only in IDLE or DONE.
- rst_n assertion mid-capture: immediate return to reset values; load falls asynchronously.

Decomposition:
- Shared package capture_pkg:
  - state encodings (ST_IDLE..ST_DONE);
  - DATA_W and CNT_W defaults;
  - an abs/saturate function for DATA_W samples.
- One sub-module, trig_detect:
  - magnitude, compare and run counter;
  - inputs din_a, dec_rdy_a, threshold, enable, clear;
  - output hit, one cycle, registered.
- The FSM and counters stay in capture_trigger.

Test Plan:
1. Reset then arm, no strobes → store_clr high for exactly 2 cycles, then state=2, load=0 indefinitely.
2. Armed, threshold=1000, TRIG_RUN=2, strobed samples 500, 1200, 800, 1200, 1300 → trigger only after the 1300 sample; load=1 one cycle later; state=3.
3. cap_len=9, strobe every 4th cycle after trigger → exactly 10 cycles with load && dec_rdy_a; done=1; sample_cnt=9; load=0 on the edge that takes the 10th sample.
4. Sample -8192 with threshold=8191 → qualifies as magnitude 8191; sample 8191 with threshold=8192 never qualifies.
5. full asserted mid-capture at sample_cnt=100 with cap_len=8191 → DONE next edge, load=0, sample_cnt=100 retained.
6. abort and arm in the same cycle during CAPTURE → state=0, load=0; a subsequent arm restarts at CLEAR with sample_cnt=0.
